// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with E0/F0 prefix folding; optional err_count output under PS2_RX_ERR_COUNT_EN
module ps2_rx_frame #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_in,
   output logic       is_extend,
   output logic       is_break,
   output logic       valid,
`ifdef PS2_RX_ERR_COUNT_EN
   output logic [7:0] err_count,
`endif
   output logic       err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                state;
   logic [2:0]            bit_cnt;
   logic [7:0]            shift;
   logic                  parity_bit;
   logic                  ext_flag;
   logic                  brk_flag;
   logic [TW-1:0]         tcnt;

   logic                  clk_s1, clk_s2;
   logic                  data_s1, data_s2;
   logic [FILTER_LEN-1:0] hist;
   logic                  filt;
   logic                  fall;
   logic                  frame_good;

   // Two-flop synchronisers for both asynchronous PS/2 lines
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   // Glitch filter: the filtered clock only moves once the whole history agrees
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         hist <= '1;
         filt <= 1'b1;
      end else begin
         hist <= {hist[FILTER_LEN-2:0], clk_s2};
         if (hist == '0)
            filt <= 1'b0;
         else if (&hist)
            filt <= 1'b1;
      end
   end

   // Falling edge of the filtered clock is the bit sample point
   assign fall = filt & ~(|hist);

   // Odd parity over data+parity, and the stop bit (sampled now) must be high
   assign frame_good = (^{shift, parity_bit}) & data_s2;

   // Frame FSM, prefix folding, timeout and output strobes
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shift      <= 8'h00;
         parity_bit <= 1'b0;
         ext_flag   <= 1'b0;
         brk_flag   <= 1'b0;
         tcnt       <= '0;
         key_in     <= 8'h00;
         is_extend  <= 1'b0;
         is_break   <= 1'b0;
         valid      <= 1'b0;
         err        <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (state == IDLE) begin
            tcnt <= '0;
            // A high start bit is treated as line noise and silently ignored
            if (fall && !data_s2) begin
               state   <= DATA;
               bit_cnt <= 3'd0;
            end
         end else if (fall) begin
            tcnt <= '0;
            if (state == DATA) begin
               shift <= {data_s2, shift[7:1]};
               if (bit_cnt == 3'd7)
                  state <= PARITY;
               else
                  bit_cnt <= bit_cnt + 3'd1;
            end else if (state == PARITY) begin
               parity_bit <= data_s2;
               state      <= STOP;
            end else begin
               state <= IDLE;
               if (!frame_good) begin
                  err      <= 1'b1;
                  ext_flag <= 1'b0;
                  brk_flag <= 1'b0;
               end else if (shift == 8'hE0) begin
                  ext_flag <= 1'b1;
               end else if (shift == 8'hF0) begin
                  brk_flag <= 1'b1;
               end else begin
                  key_in    <= shift;
                  is_extend <= ext_flag;
                  is_break  <= brk_flag;
                  valid     <= 1'b1;
                  ext_flag  <= 1'b0;
                  brk_flag  <= 1'b0;
               end
            end
         end else if (tcnt == TMAX) begin
            // Device stopped clocking mid-frame: abandon it
            state    <= IDLE;
            err      <= 1'b1;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            tcnt     <= '0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

`ifdef PS2_RX_ERR_COUNT_EN
   // Saturating count of discarded frames, cleared only by reset
   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         err_count <= 8'h00;
      else if (err && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - table-driven scoreboard bench for ps2_rx_frame
module tb_ps2_rx_frame;

   localparam int FL = 8;
   localparam int TO = 2000;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_in;
   logic       is_extend;
   logic       is_break;
   logic       valid;
   logic       err;
`ifdef PS2_RX_ERR_COUNT_EN
   logic [7:0] err_count;
`endif

   ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clock     (clock),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_in    (key_in),
      .is_extend (is_extend),
      .is_break  (is_break),
      .valid     (valid),
`ifdef PS2_RX_ERR_COUNT_EN
      .err_count (err_count),
`endif
      .err       (err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      int         strobe;   // 0 none, 1 valid, 2 err
      logic [7:0] hk;
      logic       he;
      logic       hb;
   } vec_t;

   typedef struct {
      bit         is_err;
      logic [7:0] k;
      logic       e;
      logic       b;
   } exp_t;

   vec_t tbl[12];
   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_errs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit is_err, input logic [7:0] k, input logic e, input logic b);
      exp_t x;
      x.is_err = is_err;
      x.k = k;
      x.e = e;
      x.b = b;
      sbq.push_back(x);
      if (is_err) exp_errs++;
   endtask

   task automatic scan();
      exp_t x;
      if (valid || err) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual valid=%0b err=%0b required none", valid, err);
         end else begin
            x = sbq.pop_front();
            chk("strobe_err", err, x.is_err);
            chk("strobe_valid", valid, !x.is_err);
            if (!x.is_err) begin
               chk("key_in", key_in, x.k);
               chk("is_extend", is_extend, x.e);
               chk("is_break", is_break, x.b);
            end
         end
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (!rst) scan();
      end
   endtask

   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      tick(10);
      ps2_clk = 1'b0;
      tick(20);
      ps2_clk = 1'b1;
      if (glitch) begin
         tick(6);
         ps2_clk = 1'b0;
         tick(2);
         ps2_clk = 1'b1;
         tick(2);
      end else begin
         tick(10);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int nbits, input int glitch_idx);
      logic [10:0] bits;
      bits = {stop, par, d, 1'b0};
      for (int i = 0; i < nbits; i++)
         ps2_bit(bits[i], i == glitch_idx);
      ps2_data = 1'b1;
   endtask

   task automatic chk_held(input logic [7:0] k, input logic e, input logic b);
      chk("held_key_in", key_in, k);
      chk("held_is_extend", is_extend, e);
      chk("held_is_break", is_break, b);
      chk("sb_drained", sbq.size(), 0);
   endtask

   initial begin
      tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0};
      tbl[1]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h1C, 1'b0, 1'b0};
      tbl[2]  = '{8'hF0, 1'b1, 1'b1, 0, 8'h1C, 1'b0, 1'b0};
      tbl[3]  = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1};
      tbl[4]  = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b0, 1'b0};
      tbl[5]  = '{8'h1C, 1'b1, 1'b1, 2, 8'h75, 1'b0, 1'b0};
      tbl[6]  = '{8'h1C, 1'b0, 1'b0, 2, 8'h75, 1'b0, 1'b0};
      tbl[7]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h75, 1'b0, 1'b0};
      tbl[8]  = '{8'h1C, 1'b1, 1'b1, 2, 8'h75, 1'b0, 1'b0};
      tbl[9]  = '{8'hAA, 1'b1, 1'b1, 1, 8'hAA, 1'b0, 1'b0};
      tbl[10] = '{8'hF0, 1'b1, 1'b1, 0, 8'hAA, 1'b0, 1'b0};
      tbl[11] = '{8'hFA, 1'b1, 1'b1, 1, 8'hFA, 1'b0, 1'b1};

      tick(5);
      rst = 1'b0;
      tick(1000);
      chk("reset_key_in", key_in, 8'h00);
      chk("reset_is_extend", is_extend, 1'b0);
      chk("reset_is_break", is_break, 1'b0);
      chk("reset_valid", valid, 1'b0);
      chk("reset_err", err, 1'b0);
`ifdef PS2_RX_ERR_COUNT_EN
      chk("reset_err_count", err_count, 8'h00);
`endif

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].strobe == 1) push_exp(1'b0, tbl[i].hk, tbl[i].he, tbl[i].hb);
         else if (tbl[i].strobe == 2) push_exp(1'b1, 8'h00, 1'b0, 1'b0);
         send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 11, -1);
         tick(30);
         chk_held(tbl[i].hk, tbl[i].he, tbl[i].hb);
      end
`ifdef PS2_RX_ERR_COUNT_EN
      chk("err_count_table", err_count, exp_errs);
`endif

      // Timeout: start plus three data bits, then the clock stays high
      push_exp(1'b1, 8'h00, 1'b0, 1'b0);
      send_frame(8'h2D, 1'b1, 1'b1, 4, -1);
      tick(TO + 10);
      chk("timeout_err_seen", sbq.size(), 0);
      push_exp(1'b0, 8'h2D, 1'b0, 1'b0);
      send_frame(8'h2D, 1'b1, 1'b1, 11, -1);
      tick(30);
      chk_held(8'h2D, 1'b0, 1'b0);
`ifdef PS2_RX_ERR_COUNT_EN
      chk("err_count_timeout", err_count, exp_errs);
`endif

      // Short low glitch on the clock during a data bit must be ignored
      push_exp(1'b0, 8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b1, 11, 4);
      tick(30);
      chk_held(8'h5A, 1'b0, 1'b0);

      // Reset after five bits drops the partial frame silently
      send_frame(8'hFF, 1'b1, 1'b1, 5, -1);
      rst = 1'b1;
      exp_errs = 0;
      tick(3);
      chk("midrst_key_in", key_in, 8'h00);
      chk("midrst_valid", valid, 1'b0);
      chk("midrst_err", err, 1'b0);
      rst = 1'b0;
      tick(20);
      push_exp(1'b0, 8'h33, 1'b0, 1'b0);
      send_frame(8'h33, 1'b1, 1'b1, 11, -1);
      tick(30);
      chk_held(8'h33, 1'b0, 1'b0);
`ifdef PS2_RX_ERR_COUNT_EN
      chk("err_count_after_rst", err_count, exp_errs);
`endif

      tick(50);
      chk("final_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Front-end PS/2 device-to-host receiver for the keyboard path.
- Synchronises and filters raw PS2_CLK/PS2_DATA, deserialises 11-bit frames and checks parity/stop.
- Folds E0/F0 prefix bytes into flags and presents completed scan codes to the keyboard decoder as key_in/is_extend/is_break with a valid strobe and an err strobe.
- Receive only; host-to-device transmit is out of scope.

Parameters:
- FILTER_LEN, 8, number of consecutive equal samples of synchronised ps2_clk needed to change the filtered clock level (min 2).
- TIMEOUT_CYCLES, 100000, system clocks allowed between filtered falling edges inside a frame before abort (1 ms at 100 MHz); counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clock  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ps2_clk  input  1  raw PS/2 clock line, asynchronous
- ps2_data  input  1  raw PS/2 data line, asynchronous
- key_in  output  8  last completed non-prefix scan byte
- is_extend  output  1  E0 prefix preceded key_in
- is_break  output  1  F0 prefix preceded key_in
- valid  output  1  one-cycle strobe: key_in/is_extend/is_break just updated
- err  output  1  one-cycle strobe: frame discarded

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clock. rst dominates all other events.
- Reset values: key_in=8'h00, is_extend=0, is_break=0, valid=0, err=0, state IDLE, bit counter 0, prefix flags 0, sync flops and filter history 1, filtered clock 1, timeout counter 0.
- Sync: 2-flop synchroniser on each line.
- Filter: FILTER_LEN-deep history of synced clk. Filtered clk goes 0 when all samples are 0 and 1 when all are 1; otherwise it holds.
- Sample event: filtered clk 1->0. Data is taken from synced ps2_data in the same cycle.
- FSM states and transitions:
  - IDLE: event with data=0 -> DATA, bit_cnt=0. Event with data=1 -> stay in IDLE, no err.
  - DATA: each event shifts data into shift[7] (LSB first, right shift). After the 8th event -> PARITY.
  - PARITY: event captures parity bit -> STOP.
  - STOP: event captures stop bit, then go to IDLE and evaluate the frame.
- Evaluate: the frame is good if XOR(byte, parity)=1 (odd parity) and stop=1.
  - Good byte E0: set ext flag. No valid.
  - Good byte F0: set brk flag. No valid.
  - Any other good byte (including AA, FA): next cycle key_in=byte, is_extend=ext flag, is_break=brk flag, valid=1 for exactly one cycle. Then clear both flags.
  - Bad frame: err=1 for one cycle. Flags cleared; key_in/is_extend/is_break unchanged; no valid.
- Latency: valid/err assert in the cycle after the stop-bit sample event. Sample event trails the raw clock edge by 2+FILTER_LEN cycles.
- Outputs key_in/is_extend/is_break hold until the next valid.
- Timeout: in DATA/PARITY/STOP, the counter increments each cycle and resets on each sample event. When it reaches TIMEOUT_CYCLES: go to IDLE, err pulse, flags cleared, counter 0. In IDLE the counter is held at 0.
- Prefix flags persist across frames (E0 then F0 then code). Only emitted code, err, or rst clears them.
- valid and err are never high in the same cycle.
- Reset mid-frame: immediate return to reset values; the partial frame is dropped with no strobe.

Optional Feature:
- PS2_RX_ERR_COUNT_EN defined: adds output err_count[7:0], reset 0.
  - Increments on every err strobe and saturates at 8'hFF.
  - Exception: rst clears it; nothing else does.
- PS2_RX_ERR_COUNT_EN undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, hold lines high 1000 cycles -> all outputs 0, no valid/err strobes.
- Frame 0x1C, parity 0, stop 1 -> single valid pulse; key_in=8'h1C, is_extend=0, is_break=0; outputs held afterwards.
- Frames E0 (par 0), F0 (par 1), 75 (par 0) -> exactly one valid, after the third frame; key_in=8'h75, is_extend=1, is_break=1. Following frame 0x75 -> valid with both flags 0.
- Frame 0x1C with parity 1 -> err pulse, no valid, key_in keeps prior value. Repeat with stop=0 -> err. With PS2_RX_ERR_COUNT_EN, err_count=2.
- Start + 3 data bits, then clk high for TIMEOUT_CYCLES+10 -> one err pulse, FSM in IDLE. Next frame 0x2D (par 1) -> valid, key_in=8'h2D.
- 2-cycle low glitch on ps2_clk mid-frame (< FILTER_LEN) -> no extra bit sampled, frame decodes correctly. rst asserted after 5 bits -> outputs 0, subsequent frame decodes correctly.
